// File: rtl/sync_result_sink.sv
// Result sink: buffers valid/ready results in a small FIFO and shows them one at a time on 16 LEDs.
// Optional macro SYNC_RESULT_SINK_TAG_EN puts a 4-bit display sequence number on out[15:12].
`ifndef intN
`define intN 16
`endif

module sync_result_sink #(
  parameter int WIDTH     = `intN,
  parameter int DEPTH     = 4,
  parameter int HOLD_LOG2 = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in0,
  input  logic             step_mode,
  input  logic             advance,
  output logic [15:0]      out,
  output logic [3:0]       pending,
  output logic [7:0]       seen
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic {SHOW, HOLD} state_t;

  state_t               state_reg, state_next;
  logic [HOLD_LOG2-1:0] hold_reg, hold_next;
  logic [PTR_W-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]     count_reg, count_next;
  logic [7:0]           seen_reg;
  logic [15:0]          out_reg, out_next;
  logic                 advance_q;
  logic [WIDTH-1:0]     mem [DEPTH];

  logic        push, pop, full, empty, adv_rise;
  logic [15:0] rd_ext;
  logic [4:0]  count_ext;

  assign full     = (count_reg == CNT_W'(DEPTH));
  assign empty    = (count_reg == '0);
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign adv_rise = advance && !advance_q;

  // Storage carries no reset so it can map onto distributed/block RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= in0;
  end

  generate
    if (WIDTH >= 16) begin : g_wide
      assign rd_ext = mem[rd_ptr_reg][15:0];
    end else begin : g_narrow
      assign rd_ext = {{(16 - WIDTH){1'b0}}, mem[rd_ptr_reg]};
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    hold_next  = hold_reg;
    pop        = 1'b0;
    case (state_reg)
      SHOW: begin
        if (!empty) begin
          if (!step_mode) begin
            pop        = 1'b1;
            hold_next  = '0;
            state_next = HOLD;
          end else if (adv_rise) begin
            pop = 1'b1;
          end
        end
      end
      HOLD: begin
        hold_next = hold_reg + HOLD_LOG2'(1);
        // Leaving as the counter reaches all-ones makes each auto display last 2^HOLD_LOG2 cycles.
        if (adv_rise || (hold_next == '1)) state_next = SHOW;
      end
      default: state_next = SHOW;
    endcase
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

`ifdef SYNC_RESULT_SINK_TAG_EN
  logic [3:0] tag_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    tag_reg <= 4'd0;
    else if (pop) tag_reg <= tag_reg + 4'd1;
  end

  assign out_next = pop ? {tag_reg, rd_ext[11:0]} : out_reg;
`else
  assign out_next = pop ? rd_ext : out_reg;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= SHOW;
      hold_reg   <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      seen_reg   <= 8'd0;
      out_reg    <= 16'd0;
      advance_q  <= 1'b0;
    end else begin
      state_reg <= state_next;
      hold_reg  <= hold_next;
      count_reg <= count_next;
      out_reg   <= out_next;
      advance_q <= advance;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
        seen_reg   <= seen_reg + 8'd1;
      end
      if (pop) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
    end
  end

  assign count_ext = 5'(count_reg);
  assign pending   = (count_ext > 5'd15) ? 4'd15 : count_ext[3:0];
  assign seen      = seen_reg;
  assign out       = out_reg;

endmodule

// File: tb/tb_sync_result_sink.sv
// Directed bench for sync_result_sink with DEPTH=4, HOLD_LOG2=3 (8-cycle display time).
module tb_sync_result_sink;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in0;
  logic        step_mode;
  logic        advance;
  logic [15:0] out;
  logic [3:0]  pending;
  logic [7:0]  seen;

  int n_cmp = 0;
  int n_bad = 0;

  sync_result_sink #(.WIDTH(16), .DEPTH(4), .HOLD_LOG2(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in0       (in0),
    .step_mode (step_mode),
    .advance   (advance),
    .out       (out),
    .pending   (pending),
    .seen      (seen)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic push1(input logic [15:0] v);
    in_valid = 1'b1;
    in0      = v;
    tick();
    in_valid = 1'b0;
  endtask

  logic [15:0] got_seq [8];
  int          n_chg;
  logic [15:0] last_out;
  int          max_pend;
  bit          saw_not_ready;
  int          val;
  bit          xfer;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in0 = 16'd0; step_mode = 1'b0; advance = 1'b0;
    tick();
    check("ready_in_reset", in_ready, 1);
    tick();
    reset = 1'b0;
    check("rst_out", out, 0);
    check("rst_pending", pending, 0);
    check("rst_seen", seen, 0);
    check("rst_ready", in_ready, 1);

    // Auto mode latency and hold time: 5 accepted at N, shown after N+1; 8 follows 8 cycles later.
    push1(16'd5);
    check("lat_out_before", out, 0);
    check("lat_pending", pending, 1);
    tick();
    check("lat_out_5", out, 5);
    push1(16'd8);
    repeat (6) tick();
    check("hold_still_5", out, 5);
    tick();
    check("hold_then_8", out, 8);
    check("auto_seen", seen, 2);

    // Backpressure: values 1..6 offered continuously.
    do_reset();
    val = 1; n_chg = 0; last_out = out; max_pend = 0; saw_not_ready = 0;
    for (int c = 0; c < 100; c++) begin
      in_valid = (val <= 6);
      in0      = 16'(val);
      xfer     = in_valid && in_ready;
      tick();
      if (xfer) val++;
      if (int'(pending) > max_pend) max_pend = int'(pending);
      if (!in_ready) saw_not_ready = 1;
      if (out != last_out) begin
        if (n_chg < 8) got_seq[n_chg] = out;
        n_chg++;
        last_out = out;
      end
    end
    in_valid = 1'b0;
    check("bp_max_pending", max_pend, 4);
    check("bp_ready_dropped", saw_not_ready, 1);
    check("bp_n_displayed", n_chg, 6);
    for (int i = 0; i < 6; i++) check($sformatf("bp_seq%0d", i), got_seq[i], i + 1);
    check("bp_seen", seen, 6);
    check("bp_drained", pending, 0);

    // Step mode: only advance rises pop.
    do_reset();
    step_mode = 1'b1;
    push1(16'd13);
    push1(16'd21);
    push1(16'd34);
    repeat (3) tick();
    check("step_idle_out", out, 0);
    check("step_pending", pending, 3);
    advance = 1'b1;
    tick();
    check("step_first", out, 13);
    repeat (10) tick();
    check("step_held_high", out, 13);
    check("step_held_pend", pending, 2);
    advance = 1'b0; tick(); advance = 1'b1; tick();
    check("step_second", out, 21);
    advance = 1'b0; tick(); advance = 1'b1; tick();
    check("step_third", out, 34);
    advance = 1'b0; tick(); advance = 1'b1; tick();
    check("step_empty_keep", out, 34);
    advance = 1'b0;
    step_mode = 1'b0;

    // Early skip: rise 3 cycles into HOLD -> SHOW, next edge pops the second value.
    do_reset();
    push1(16'd40);
    push1(16'd50);
    check("skip_first", out, 40);
    repeat (3) tick();
    advance = 1'b1;
    tick();
    advance = 1'b0;
    check("skip_decision", out, 40);
    tick();
    check("skip_second", out, 50);

    // Asynchronous reset in the middle of a hold.
    do_reset();
    push1(16'd77);
    push1(16'd78);
    tick();
    check("ar_pre_out", out, 77);
    check("ar_pre_pending", pending, 1);
    reset = 1'b1;
    #1;
    check("ar_out", out, 0);
    check("ar_pending", pending, 0);
    check("ar_seen", seen, 0);
    check("ar_ready", in_ready, 1);
    tick();
    reset = 1'b0;

    // Tagged or plain display of two results.
    do_reset();
    push1(16'h0123);
    push1(16'h0456);
    check("tag_first", out, 16'h0123);
    repeat (8) tick();
`ifdef SYNC_RESULT_SINK_TAG_EN
    check("tag_second", out, 16'h1456);
`else
    check("tag_second", out, 16'h0456);
`endif

    // seen wraps after 256 accepts.
    do_reset();
    val = 0;
    for (int c = 0; c < 4000 && val < 256; c++) begin
      in_valid = 1'b1;
      in0      = 16'(val);
      xfer     = in_ready;
      tick();
      if (xfer) val++;
    end
    in_valid = 1'b0;
    check("wrap_accepted", val, 256);
    check("wrap_seen", seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sync_result_sink.md
# sync_result_sink

Consumer end of the valid/ready result stream produced by generated `tests_*` modules on the FPGA board top. It accepts results via handshake, buffers them in a small FIFO, and presents them one at a time on the 16-bit LED output. Each result is held for a programmable time, or until a push-button step. It replaces the bare `assign out = b` path so that no result is lost when results arrive faster than a human can read them.

## Interface
- `WIDTH`, default `` `intN `` (16): result width.
- `DEPTH`, default 4: FIFO entries; must be a power of two, 2..16.
- `HOLD_LOG2`, default 26: auto-advance hold time is 2^HOLD_LOG2 cycles.
- `clk`  in  1  clock; all state is updated on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  result available from the producer.
- `in_ready`  out  1  sink can accept; combinational, `!full`.
- `in0`  in  WIDTH  result data.
- `step_mode`  in  1  0 = auto-advance after the hold time; 1 = advance only on `advance`.
- `advance`  in  1  already-debounced button level; acts on its rising edge.
- `out`  out  16  display value.
- `pending`  out  4  FIFO occupancy, saturating at 15.
- `seen`  out  8  count of accepted results, wraps 255 -> 0.

## Operation
- Accept: a transfer occurs on a `clk` edge when `in_valid && in_ready`. `in0` is written at the write pointer, and the write pointer and `seen` increment.
- FIFO rules:
  - Occupancy is held in a counter 0..DEPTH; `full` = (count == DEPTH); `empty` = (count == 0).
  - Pointers wrap modulo DEPTH.
  - Push and pop in the same cycle leave the count unchanged.
  - There is no bypass: a value pushed into an empty FIFO is poppable on the next edge at the earliest.
- Display FSM, two states:
  - SHOW: a value is displayed and the hold is complete, or the block has just come out of reset.
  - HOLD: the hold counter is running.
- Transitions:
  - Reset -> SHOW, with `out`=0.
  - SHOW, !empty, step_mode=0 -> pop into the display register, clear the hold counter, go to HOLD.
  - SHOW, !empty, step_mode=1, `advance` rising edge -> pop, go to SHOW. There is no hold in step mode.
  - HOLD: the counter increments each cycle. At all-ones (2^HOLD_LOG2 - 1) -> SHOW.
  - HOLD, `advance` rising edge -> SHOW immediately (early skip), independent of step_mode.
  - SHOW, empty -> stay in SHOW; `out` keeps the last value.
- Edge detect: `advance` is registered once; rising edge = `advance && !advance_q`. `advance_q` resets to 0.
- Width: for WIDTH < 16, `out` is zero-extended. For WIDTH > 16, the low 16 bits are shown.
- Changing `step_mode` mid-HOLD does not abort the hold. The new mode applies at the next SHOW decision.

## Timing
- Reset values: `out`=0, `pending`=0, `seen`=0, FIFO pointers 0, state SHOW, hold counter 0. `in_ready`=1 while `reset` is high and immediately after.
- Accept-to-display latency into an empty FIFO, auto mode, in SHOW:
  - The value is accepted at edge N.
  - It appears on `out` after edge N+1.
- Throughput: one accept per cycle until full.
- When full, `in_ready` drops after the filling edge and rises after the edge that pops.
- A pop and an accept on the same edge when full is impossible, because `in_ready` is 0 on that cycle.
- Reset asserted mid-operation clears all state, including buffered results, asynchronously. Any result offered during reset is not counted.

## Configuration
- `SYNC_RESULT_SINK_TAG_EN`
  - Defined: `out[15:12]` = low 4 bits of the sequence number of the displayed result (0 for the first result after reset), and `out[11:0]` = low 12 bits of the result.
  - Undefined: `out` = result per the width rule, with no tag logic.

## Test plan
- Reset, then release: `out`=0, `pending`=0, `seen`=0, `in_ready`=1. Assert `reset` asynchronously mid-HOLD: all outputs return to 0 without a clock edge.
- Auto mode, HOLD_LOG2=3: push 5 at cycle 0 -> `out`=5 after cycle 1. Push 8 at cycle 2 -> `out`=8 exactly 8 cycles after 5 was loaded.
- Backpressure, DEPTH=4, HOLD_LOG2=3, `in_valid` held high with values 1..6:
  - `pending` reaches 4 and `in_ready`=0.
  - No value is lost or duplicated; `out` sequence is 1,2,3,4,5,6.
  - `seen`=6.
- Step mode: push 13, 21, 34 -> `out` stays 0 until the first `advance` rise, then shows 13.
  - Holding `advance` high for 10 cycles advances only once.
  - Two more rises show 21 and then 34; a further rise keeps 34.
- Early skip: auto mode, HOLD_LOG2=10, two values queued. An `advance` rise 3 cycles into HOLD shows the second value on the following decision edge.
- With `SYNC_RESULT_SINK_TAG_EN`: push 0x0123, 0x0456 -> `out`=0x0123, then 0x1456.
- Wrap of `seen`: push 256 results -> `seen`=0.
